ula_pipe: RTL and testbench
===========================

Name: ula_pipe

Overview:
- Parametrised, handshaked successor of the processor's combinational ALU. Operands and an opcode enter through a valid/ready interface; result and [Z N V] flags leave through a registered valid/ready interface.
- Single-cycle ops have 1-cycle latency. MUL is an iterative shift-add unit taking WIDTH cycles.
- Sits in the EX stage of the pipelined core. Back-pressure from the MEM stage stalls it.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of 2).
- MUL_EN, 1, 1 enables iterative MUL. 0 makes MUL behave as an undefined code.
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at CLK edge.
- CodeULA  in  4  opcode.
- OpA  in  WIDTH  operand A.
- OpB  in  WIDTH  operand B.
- out_valid  out  1  Res/FlagReg valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- Res  out  WIDTH  registered result.
- FlagReg  out  3  registered flags: bit2 Z, bit1 N, bit0 V.
- busy  out  1  high while MUL iterates.

Behaviour:
- Reset (async, any state, including mid-MUL) sets:
  - state=IDLE, out_valid=0, Res=0, FlagReg=3'b000, busy=0, iteration counter=0.
  - An in-flight MUL is discarded.
- Opcodes (A=OpA, B=OpB, all modulo 2^WIDTH):
  - 0000 ADD: A+B.
  - 0001 SUB: A+~B+1.
  - 0010 SLT: 1 if A>B unsigned, else 0.
  - 0011 AND, 0100 OR, 0101 XOR.
  - 0110 BEZ: Res=B; Z=(A==0); N=V=0.
  - 0111 NOP: Res=0.
  - 1000 SHL: A<<B[SHW-1:0].
  - 1001 SHR: logical right shift.
  - 1010 SRA: arithmetic right shift.
  - 1011 MUL: unsigned A*B, low WIDTH bits.
  - 1100 SLTS: 1 if A>B signed.
  - 1101-1111 (and MUL when MUL_EN=0): Res=0, flags Z=1 N=0 V=0.
- Flags are always computed from the final result value, never from the previous Res:
  - Z=(result==0), except BEZ.
  - N=result[WIDTH-1] for every op except BEZ/NOP/undefined.
  - V for ADD: signed overflow (operand signs equal, result sign differs).
  - V for SUB: the same rule applied to A and (~B+1).
  - V for MUL: 1 if the upper WIDTH product bits are nonzero.
  - V=0 for all other ops.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Combinational from state, out_valid and out_ready only; never depends on in_valid.
- Single-cycle op accepted at edge k:
  - Res/FlagReg load and out_valid=1 at edge k.
  - Visible in cycle k+1.
- Output hold:
  - While out_valid & ~out_ready, Res/FlagReg/out_valid are held stable and in_ready=0.
  - On out_ready with no new accept, out_valid clears at the next edge.
  - Simultaneous drain and accept gives back-to-back results with no bubble.
- FSM states: IDLE, MUL_RUN.
  - IDLE -> MUL_RUN on accept of MUL (MUL_EN=1). Latch A, B; clear accumulator; cnt=0; busy=1.
  - MUL_RUN: each edge, if B_sh[0] add A_sh to a 2*WIDTH accumulator; A_sh<<=1; B_sh>>=1; cnt++.
  - When cnt reaches WIDTH-1, that edge loads Res=acc low half, sets flags and out_valid=1, and returns to IDLE with busy=0.
  - MUL latency is WIDTH cycles from accept to out_valid visible. in_ready=0 throughout MUL_RUN.
  - MUL_RUN is only entered when the output is free or draining. out_valid is therefore 0 on completion, and no result is overwritten.
- in_valid without in_ready: ignored; the block does not sample operands.
- CodeULA/OpA/OpB are don't-care when in_valid=0.

Decomposition:
- Shared package ula_pkg holds:
  - opcode localparams (OP_ADD..OP_SLTS).
  - flag bit indices (FLAG_Z=2, FLAG_N=1, FLAG_V=0).
  - state encoding (ST_IDLE, ST_MUL_RUN).
- One sub-module, ula_mul_iter: the WIDTH-cycle shift-add multiplier with start/done, returning the 2*WIDTH product.
- The single-cycle datapath and flag logic stay in ula_pipe.

Test Plan:
- Reset: RST asserted mid-stream -> out_valid=0, Res=0, FlagReg=000, in_ready=1 immediately after release.
- ADD 0x7FFF+0x0001, out_ready=1 -> next cycle Res=0x8000, FlagReg=011 (N=1, V=1).
- SUB 0x0005-0x0005 -> Res=0x0000, FlagReg=100. Then BEZ A=0, B=0x0040 -> Res=0x0040, FlagReg=100.
- MUL 0x0100*0x0101 (WIDTH=16) -> busy=1 and in_ready=0 for 16 cycles. Then Res=0x0100, FlagReg=001 (V=1, product 0x10100).
- Back-pressure: out_ready=0 for 3 cycles after XOR 0xFF00^0x0FF0 -> Res=0xF0F0, FlagReg=010, held stable, in_ready=0. Release gives one transfer.
- Streaming SRA 0x8000>>4, SLTS 0xFFFF vs 0x0001, code 1111 with out_ready=1 -> three consecutive results: 0xF800/010, 0x0000/100, 0x0000/100.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and FSM states.
package ula_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_BEZ  = 4'b0110;
    localparam logic [3:0] OP_NOP  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_SLTS = 4'b1100;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    // Two's-complement overflow of x+y given the three sign bits.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module ula_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_a_sh;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b_sh;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    // The final partial product is folded in combinationally so the owner
    // can capture the complete product on the same edge as the last step.
    assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
    assign w_last     = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_done     = w_last;
    assign o_product  = w_acc_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_a_sh <= {{WIDTH{1'b0}}, i_a};
            r_b_sh <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            if (w_last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ula_pipe.sv
// Handshaked EX-stage ALU: single-cycle ops register in one edge, MUL runs
// through the iterative multiplier; result and Z/N/V flags are registered.
module ula_pipe
    import ula_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       CodeULA,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Res,
    output logic [2:0]       FlagReg,
    output logic             busy
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_res;
    logic [2:0]         r_flags;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_neg_b;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res;
    logic [2:0]         w_flags;
    logic [2:0]         w_mul_flags;

    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = MUL_EN && (CodeULA == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;

    assign out_valid = r_out_valid;
    assign Res       = r_res;
    assign FlagReg   = r_flags;
    assign busy      = r_busy;

    assign w_neg_b = ~OpB + WIDTH'(1);
    assign w_sum   = OpA + OpB;
    assign w_diff  = OpA + w_neg_b;
    assign w_sh    = OpB[SHW-1:0];

    // Single-cycle datapath; flags default to the generic Z/N rule and are
    // overridden where an opcode defines them differently.
    always_comb begin
        w_res   = '0;
        w_flags = 3'b000;
        case (CodeULA)
            OP_ADD:  w_res = w_sum;
            OP_SUB:  w_res = w_diff;
            OP_SLT:  w_res = WIDTH'(OpA > OpB);
            OP_AND:  w_res = OpA & OpB;
            OP_OR:   w_res = OpA | OpB;
            OP_XOR:  w_res = OpA ^ OpB;
            OP_BEZ:  w_res = OpB;
            OP_NOP:  w_res = '0;
            OP_SHL:  w_res = OpA << w_sh;
            OP_SHR:  w_res = OpA >> w_sh;
            OP_SRA:  w_res = $signed(OpA) >>> w_sh;
            OP_SLTS: w_res = WIDTH'($signed(OpA) > $signed(OpB));
            default: w_res = '0;
        endcase

        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_N] = w_res[WIDTH-1];
        w_flags[FLAG_V] = 1'b0;
        case (CodeULA)
            OP_ADD: w_flags[FLAG_V] = add_ovf(OpA[WIDTH-1], OpB[WIDTH-1], w_sum[WIDTH-1]);
            OP_SUB: w_flags[FLAG_V] = add_ovf(OpA[WIDTH-1], w_neg_b[WIDTH-1], w_diff[WIDTH-1]);
            OP_BEZ: begin
                w_flags[FLAG_Z] = (OpA == '0);
                w_flags[FLAG_N] = 1'b0;
            end
            OP_NOP: w_flags[FLAG_N] = 1'b0;
            OP_SLT, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA, OP_SLTS: ;
            default: begin
                w_flags[FLAG_Z] = 1'b1;
                w_flags[FLAG_N] = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_mul_flags         = 3'b000;
        w_mul_flags[FLAG_Z] = (w_product[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_N] = w_product[WIDTH-1];
        w_mul_flags[FLAG_V] = |w_product[2*WIDTH-1:WIDTH];
    end

    generate
        if (MUL_EN) begin : g_mul
            ula_mul_iter #(
                .WIDTH(WIDTH)
            ) u_mul (
                .i_clk    (CLK),
                .i_rst    (RST),
                .i_start  (w_mul_start),
                .i_a      (OpA),
                .i_b      (OpB),
                .o_done   (w_mul_done),
                .o_product(w_product)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_product  = '0;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_flags     <= 3'b000;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        // Output is free or draining this edge, so the MUL
                        // result can never overwrite an unconsumed value.
                        r_state     <= ST_MUL_RUN;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_res       <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_MUL_RUN: begin
                    if (w_mul_done) begin
                        r_res       <= w_product[WIDTH-1:0];
                        r_flags     <= w_mul_flags;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_pipe.sv
// Self-checking bench for ula_pipe: vector table plus hand-written sequences,
// with a queue scoreboard compared whenever an output transfer occurs.
module tb_ula_pipe;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  CodeULA;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Res;
    logic [2:0]  FlagReg;
    logic        busy;

    ula_pipe #(
        .WIDTH (16),
        .MUL_EN(1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .CodeULA  (CodeULA),
        .OpA      (OpA),
        .OpB      (OpB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Res      (Res),
        .FlagReg  (FlagReg),
        .busy     (busy)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flags;
    } vec_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    int   n_push = 0;
    int   cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge when both sides are high.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got Res=%h FlagReg=%b required no output", Res, FlagReg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %0d: Res=%h FlagReg=%b expect Res=%h FlagReg=%b", n_xfer, Res, FlagReg, e.res, e.flags);
                chk("result", {13'd0, Res, FlagReg}, {13'd0, e.res, e.flags});
            end
            n_xfer++;
            pop_cyc.push_back(cyc);
        end
    end

    // Presents one operation and holds it until accepted; returns just after the accept edge.
    task automatic send(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [2:0] ef);
        bit ok;
        int n;
        CodeULA  = c;
        OpA      = a;
        OpB      = b;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge CLK);
            if (in_ready) begin
                exp_q.push_back('{res: er, flags: ef});
                n_push++;
                ok = 1'b1;
            end
            n++;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        chk("accept_in_time", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    vec_t vecs[16];

    initial begin
        int cnt;
        int x0;
        int sz;

        vecs[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 3'b011};
        vecs[1]  = '{4'b0001, 16'h0005, 16'h0005, 16'h0000, 3'b100};
        vecs[2]  = '{4'b0110, 16'h0000, 16'h0040, 16'h0040, 3'b100};
        vecs[3]  = '{4'b0010, 16'h0003, 16'h0002, 16'h0001, 3'b000};
        vecs[4]  = '{4'b0010, 16'h0002, 16'h0003, 16'h0000, 3'b100};
        vecs[5]  = '{4'b0011, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
        vecs[6]  = '{4'b0100, 16'h8000, 16'h0001, 16'h8001, 3'b010};
        vecs[7]  = '{4'b1000, 16'h0001, 16'h000F, 16'h8000, 3'b010};
        vecs[8]  = '{4'b1000, 16'h0001, 16'h0013, 16'h0008, 3'b000};
        vecs[9]  = '{4'b1001, 16'h8000, 16'h0004, 16'h0800, 3'b000};
        vecs[10] = '{4'b0111, 16'h1234, 16'h5678, 16'h0000, 3'b100};
        vecs[11] = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 3'b100};
        vecs[12] = '{4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 3'b001};
        vecs[13] = '{4'b1011, 16'h0003, 16'h0005, 16'h000F, 3'b000};
        vecs[14] = '{4'b1011, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b001};
        vecs[15] = '{4'b1101, 16'h1111, 16'h2222, 16'h0000, 3'b100};

        RST       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        CodeULA   = 4'b0000;
        OpA       = 16'h0000;
        OpB       = 16'h0000;
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res", {16'd0, Res}, 32'd0);
        chk("rst_flags", {29'd0, FlagReg}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 16; i++)
            send(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
        drain();

        // MUL: busy and in_ready=0 for exactly WIDTH cycles, then the result.
        send(4'b1011, 16'h0100, 16'h0101, 16'h0100, 3'b001);
        cnt = 0;
        @(negedge CLK);
        while (busy && cnt < 100) begin
            chk("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
            cnt++;
            @(negedge CLK);
        end
        chk("mul_busy_cycles", cnt, 16);
        chk("mul_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge CLK);
        #1;
        drain();

        // Back-pressure: the result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(4'b0101, 16'hFF00, 16'h0FF0, 16'hF0F0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_res", {16'd0, Res}, 32'h0000F0F0);
            chk("hold_flags", {29'd0, FlagReg}, 32'd2);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge CLK);
        #1;
        x0 = n_xfer;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("release_valid_clear", {31'd0, out_valid}, 32'd0);
        chk("release_one_xfer", n_xfer - x0, 1);

        // Streaming: three results on consecutive cycles.
        send(4'b1010, 16'h8000, 16'h0004, 16'hF800, 3'b010);
        send(4'b1100, 16'hFFFF, 16'h0001, 16'h0000, 3'b100);
        send(4'b1111, 16'h0101, 16'h0202, 16'h0000, 3'b100);
        drain();
        sz = pop_cyc.size();
        chk("stream_no_bubble", pop_cyc[sz-1] - pop_cyc[sz-3], 2);

        // Reset in the middle of a MUL: the partial product must be discarded.
        CodeULA  = 4'b1011;
        OpA      = 16'h1234;
        OpB      = 16'h0003;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_res", {16'd0, Res}, 32'd0);
        chk("midrst_flags", {29'd0, FlagReg}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (25) @(posedge CLK);
        #1;
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);
        chk("xfer_total", n_xfer, n_push);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
